// File: rtl/cnt_up_stopwatch.sv
// 4-digit BCD count-up stopwatch with prescaler, start/stop/clear FSM and a
// lap-freeze display latch over a single-edge rippling decade cascade.
module cnt_up_stopwatch #(
  parameter int TICK_DIV = 50000000,
  parameter bit WRAP     = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_SS,
  input  logic       BTN_CLR,
  input  logic       BTN_LAP,
  output logic [3:0] VAL0,
  output logic [3:0] VAL1,
  output logic [3:0] VAL2,
  output logic [3:0] VAL3,
  output logic       RUN,
  output logic       LAP,
  output logic       OVF,
  output logic       TICK
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_t;

  state_t              state;
  logic [PW-1:0]       presc;
  logic [3:0][3:0]     cnt;
  logic [3:0][3:0]     snap;
  logic [3:0][3:0]     cnt_inc;
  logic [3:0][3:0]     disp;
  logic                carry;
  logic                all_nine;
  logic                lap_q;
  logic                ovf_q;
  logic                tick;
  logic                lap_toggle;
  logic                sat_pause;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt[i] == 4'd9) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    all_nine = carry;
  end

  assign tick       = (state == ST_RUN) && (presc == PRESC_MAX);
  assign lap_toggle = BTN_LAP && (state != ST_IDLE);
  // Only the first overflow auto-pauses; once saturated, further ticks are no-ops.
  assign sat_pause  = tick && all_nine && !WRAP && !ovf_q;
  assign disp       = lap_q ? snap : cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block take priority.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      presc <= '0;
      cnt   <= '0;
      snap  <= '0;
      lap_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (lap_toggle) begin
        lap_q <= !lap_q;
        if (!lap_q) snap <= cnt;
      end
      unique case (state)
        ST_IDLE: begin
          if (BTN_CLR) begin
            presc <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            lap_q <= 1'b0;
          end else if (BTN_SS) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (!all_nine) begin
              cnt <= cnt_inc;
            end else begin
              ovf_q <= 1'b1;
              if (WRAP) cnt <= '0;
            end
          end
          if (BTN_SS || sat_pause) state <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (BTN_CLR) begin
            state <= ST_IDLE;
            presc <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            lap_q <= 1'b0;
          end else if (BTN_SS) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign VAL0 = disp[0];
  assign VAL1 = disp[1];
  assign VAL2 = disp[2];
  assign VAL3 = disp[3];
  assign RUN  = (state == ST_RUN);
  assign LAP  = lap_q;
  assign OVF  = ovf_q;
  assign TICK = tick;

endmodule
